dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pkg.sv | 12 +
 rtl/dff_stage.sv | 39 +++
 rtl/dff_pipe.sv | 72 +++++++
 tb/tb_dff_pipe.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the dff_pipe valid/data delay line.
package dff_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_STAGES = 4;

    // Bits needed to count 0..stages inclusive.
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: a valid flop plus a data flop with enable, flush and
// optional hold-on-invalid gating of the data register.
module dff_stage #(
    parameter int unsigned    WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter bit             HOLD_ON_INVALID = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (!HOLD_ON_INVALID || i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// Parameterised valid/data delay line of STAGES registers with enable,
// synchronous flush and a registered occupancy counter.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH           = DEF_WIDTH,
    parameter int unsigned      STAGES          = DEF_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0,
    parameter bit               HOLD_ON_INVALID = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               d,
    output logic [WIDTH-1:0]               q,
    output logic                           out_valid,
    output logic [occ_width(STAGES)-1:0]   occ
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES:0]  w_v;
    logic [WIDTH-1:0] w_d [0:STAGES];
    logic [OCC_W-1:0] r_occ;
    logic             w_enter;
    logic             w_leave;

    assign w_v[0] = in_valid;
    assign w_d[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        dff_stage #(
            .WIDTH          (WIDTH),
            .RESET_VAL      (RESET_VAL),
            .HOLD_ON_INVALID(HOLD_ON_INVALID)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en),
            .i_flush(flush),
            .i_valid(w_v[k]),
            .i_data (w_d[k]),
            .o_valid(w_v[k+1]),
            .o_data (w_d[k+1])
        );
    end

    // Occupancy tracks the word entering stage 0 and the word leaving the last stage.
    assign w_enter = in_valid;
    assign w_leave = w_v[STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (en) begin
            if (w_enter && !w_leave) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_enter && w_leave) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign q         = w_d[STAGES];
    assign out_valid = w_v[STAGES];
    assign occ       = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench: a 3-stage hold pipe, a 3-stage follow pipe
// and a 1-stage pipe driven by shared stimulus.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [7:0] d;

    logic [7:0] q3, qh, q1;
    logic       ov3, ovh, ov1;
    logic [1:0] occ3, occh;
    logic       occ1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00), .HOLD_ON_INVALID(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q3), .out_valid(ov3), .occ(occ3)
    );

    dff_pipe #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00), .HOLD_ON_INVALID(1'b0)) u_dut_h0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(qh), .out_valid(ovh), .occ(occh)
    );

    dff_pipe #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h00), .HOLD_ON_INVALID(1'b1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q1), .out_valid(ov1), .occ(occ1)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [7:0] data);
        en = e; flush = f; in_valid = v; d = data;
    endtask

    task automatic chk3(input string tag, input logic [7:0] eq, input logic ev, input logic [1:0] eo);
        check({tag, ".q"},   64'(q3),   64'(eq));
        check({tag, ".ov"},  64'(ov3),  64'(ev));
        check({tag, ".occ"}, 64'(occ3), 64'(eo));
    endtask

    initial begin
        // Reset state, asserted away from any edge
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #3;
        chk3("rst", 8'h00, 1'b0, 2'd0);
        check("rst.s1.ov", 64'(ov1), 64'd0);
        check("rst.s1.occ", 64'(occ1), 64'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming three words back to back
        drive(1'b1, 1'b0, 1'b1, 8'hA1); step();
        check("str1.occ", 64'(occ3), 64'd1);
        check("str1.ov",  64'(ov3),  64'd0);
        check("str1.s1.q",  64'(q1), 64'hA1);
        check("str1.s1.ov", 64'(ov1), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 8'hB2); step();
        check("str2.occ", 64'(occ3), 64'd2);
        drive(1'b1, 1'b0, 1'b1, 8'hC3); step();
        chk3("str3", 8'hA1, 1'b1, 2'd3);
        drive(1'b1, 1'b0, 1'b1, 8'hD4); step();
        chk3("str4", 8'hB2, 1'b1, 2'd3);
        drive(1'b1, 1'b0, 1'b1, 8'hE5); step();
        chk3("str5", 8'hC3, 1'b1, 2'd3);

        // Asynchronous reset mid-cycle with three words in flight
        #2;
        rst_n = 1'b0;
        #1;
        chk3("arst", 8'h00, 1'b0, 2'd0);
        check("arst.h0.ov", 64'(ovh), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall: one word in, four disabled edges, then two enabled edges
        drive(1'b1, 1'b0, 1'b1, 8'h5A); step();
        check("stl.acc.occ", 64'(occ3), 64'd1);
        check("stl.acc.s1.q", 64'(q1), 64'h5A);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'h77); step();
            chk3("stl.hold", 8'h00, 1'b0, 2'd1);
            check("stl.hold.s1.q", 64'(q1), 64'h5A);
            check("stl.hold.s1.occ", 64'(occ1), 64'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        chk3("stl.e1", 8'h00, 1'b0, 2'd1);
        check("stl.e1.s1.ov", 64'(ov1), 64'd0);
        check("stl.e1.s1.occ", 64'(occ1), 64'd0);
        step();
        chk3("stl.e2", 8'h5A, 1'b1, 2'd1);

        // Fill, then flush with a valid word on d
        drive(1'b1, 1'b0, 1'b1, 8'h01); step();
        drive(1'b1, 1'b0, 1'b1, 8'h02); step();
        drive(1'b1, 1'b0, 1'b1, 8'h03); step();
        chk3("full", 8'h01, 1'b1, 2'd3);
        drive(1'b1, 1'b1, 1'b1, 8'hFF); step();
        chk3("flush", 8'h00, 1'b0, 2'd0);
        check("flush.s1.q", 64'(q1), 64'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00); step();
            chk3("flush.drain", 8'h00, 1'b0, 2'd0);
        end

        // Flush wins over en=0
        drive(1'b1, 1'b0, 1'b1, 8'h42); step();
        check("fl0.pre.occ", 64'(occ3), 64'd1);
        drive(1'b0, 1'b1, 1'b1, 8'h42); step();
        check("fl0.occ", 64'(occ3), 64'd0);
        check("fl0.s1.q",  64'(q1), 64'h00);
        check("fl0.s1.ov", 64'(ov1), 64'd0);

        // Hold-on-invalid versus data-follows
        drive(1'b1, 1'b0, 1'b1, 8'h11); step();
        drive(1'b1, 1'b0, 1'b0, 8'h99); step();
        check("hld.s1.q",  64'(q1), 64'h11);
        check("hld.s1.ov", 64'(ov1), 64'd0);
        step();
        chk3("hld.out", 8'h11, 1'b1, 2'd1);
        check("hld.h0.q", 64'(qh), 64'h11);
        step();
        chk3("hld.inv", 8'h11, 1'b0, 2'd0);
        check("hld.h0.q2",  64'(qh), 64'h99);
        check("hld.h0.ov2", 64'(ovh), 64'd0);

        // Single-stage pipe occupancy toggling
        drive(1'b1, 1'b0, 1'b1, 8'h3C); step();
        check("s1.a.q",   64'(q1), 64'h3C);
        check("s1.a.ov",  64'(ov1), 64'd1);
        check("s1.a.occ", 64'(occ1), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h3C); step();
        check("s1.b.occ", 64'(occ1), 64'd0);
        drive(1'b1, 1'b0, 1'b1, 8'h3C); step();
        check("s1.c.occ", 64'(occ1), 64'd1);
        check("s1.c.q",   64'(q1), 64'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
